// File: rtl/ssd1306_spi_pkg.sv
// Shared definitions for the SSD1306 4-wire SPI transmitter.
//   spi_state_t : shifter FSM states (IDLE, SHIFT, HOLD)
//   WORD_W      : FIFO word width, {dc, byte}
//   BIT_IDX_W   : width of the bit-within-byte counter
//   PIN_*       : uo_out pin positions of the SPI signals
package ssd1306_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } spi_state_t;

  localparam int WORD_W    = 9;
  localparam int BIT_IDX_W = 3;

  localparam int PIN_SCK = 1;
  localparam int PIN_SD  = 2;
  localparam int PIN_CS  = 3;
  localparam int PIN_DC  = 4;

endpackage

// File: rtl/ssd1306_spi4_tx_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the FIFO)
//   push, wr_data   write request and word; ignored while full
//   pop, rd_data    read request; rd_data shows the head word whenever non-empty
//   full, empty     derived from the registered count
//   count           occupancy, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module sync_fifo
  import ssd1306_spi_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ssd1306_spi4_tx.sv
// ssd1306_spi4_tx: queues {dc,byte} words and shifts them out as SPI mode 0,
// MSB first, with chip select held low across back-to-back bytes.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (aborts any transfer)
//   clk_div_i     SCK half-period H = clk_div_i+1 clocks, sampled at byte load
//   tx_valid_i    word offered; tx_data_i byte, tx_dc_i D/C level
//   tx_ready_o    FIFO not full; a word is taken when valid && ready at a rising edge
//   busy_o        FIFO non-empty or shifter active
//   cs_o, sck_o, sd_o, dc_o   registered SPI pins
//   dbg_state_o   current shifter state (spi_state_t encoding)
// Handshake: a word transfers on the rising clk edge where tx_valid_i and
// tx_ready_o are both high; tx_ready_o depends only on registered state.
module ssd1306_spi4_tx
  import ssd1306_spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] clk_div_i,
  input  logic             tx_valid_i,
  input  logic [7:0]       tx_data_i,
  input  logic             tx_dc_i,
  output logic             tx_ready_o,
  output logic             busy_o,
  output logic             cs_o,
  output logic             sck_o,
  output logic             sd_o,
  output logic             dc_o,
  output logic [1:0]       dbg_state_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  spi_state_t state_q, state_d;

  logic [WORD_W-1:0]    rd_word;
  logic                 fifo_full, fifo_empty, pop;
  logic [CNT_W-1:0]     fifo_count;

  // Counter holds remaining cycles of the current phase minus one, so the
  // latched half-period is stored as clk_div_i (= H-1) directly.
  logic [DIV_W-1:0]     half_q, half_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0] bit_q, bit_d;
  logic [7:0]           sh_q, sh_d;
  logic                 cs_q, cs_d, sck_q, sck_d, sd_q, sd_d, dc_q, dc_d;

  logic phase_done, last_bit, byte_end, do_load;

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tx_valid_i),
    .wr_data ({tx_dc_i, tx_data_i}),
    .pop     (pop),
    .rd_data (rd_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign phase_done = (cnt_q == '0);
  assign last_bit   = (bit_q == BIT_IDX_W'(7));
  // End of the 8th high phase: sck falls here and the next byte may chain.
  assign byte_end   = (state_q == SHIFT) && phase_done && sck_q && last_bit;
  assign do_load    = !fifo_empty && ((state_q == IDLE) || byte_end);

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      half_q  <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      sd_q    <= 1'b0;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      sd_q    <= sd_d;
      dc_q    <= dc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = SHIFT;
      SHIFT:   if (byte_end && fifo_empty) state_d = HOLD;
      HOLD:    if (phase_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    pop    = 1'b0;
    half_d = half_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    cs_d   = cs_q;
    sck_d  = sck_q;
    sd_d   = sd_q;
    dc_d   = dc_q;
    case (state_q)
      SHIFT: begin
        if (!phase_done) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else if (!sck_q) begin
          sck_d = 1'b1;
          cnt_d = half_q;
        end else begin
          // Falling edge: data moves in the same cycle, never while sck is high.
          sck_d = 1'b0;
          cnt_d = half_q;
          if (!last_bit) begin
            bit_d = bit_q + BIT_IDX_W'(1);
            sh_d  = {sh_q[6:0], 1'b0};
            sd_d  = sh_q[6];
          end
        end
      end
      HOLD: begin
        if (!phase_done) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          cs_d = 1'b1;
          sd_d = 1'b0;
        end
      end
      default: ;
    endcase
    // A load overrides the per-state values: from IDLE, or chaining at byte end.
    if (do_load) begin
      pop    = 1'b1;
      cs_d   = 1'b0;
      sck_d  = 1'b0;
      dc_d   = rd_word[8];
      sd_d   = rd_word[7];
      sh_d   = rd_word[7:0];
      half_d = clk_div_i;
      cnt_d  = clk_div_i;
      bit_d  = '0;
    end
  end

  assign tx_ready_o  = !fifo_full;
  assign busy_o      = (fifo_count != '0) || (state_q != IDLE);
  assign cs_o        = cs_q;
  assign sck_o       = sck_q;
  assign sd_o        = sd_q;
  assign dc_o        = dc_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ssd1306_spi4_tx.sv
// Bench for ssd1306_spi4_tx: an SPI receiver model decodes the pins into
// {dc,byte} words, per-byte timing and chip-select run lengths; these are
// compared with what the bench pushed and what the SPI timing rules predict.
module tb_ssd1306_spi4_tx;

  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 8;
  localparam int LIMIT      = 5000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DIV_W-1:0] clk_div_i = '0;
  logic             tx_valid_i = 1'b0;
  logic [7:0]       tx_data_i = '0;
  logic             tx_dc_i = 1'b0;
  logic             tx_ready_o, busy_o, cs_o, sck_o, sd_o, dc_o;
  logic [1:0]       dbg_state_o;

  ssd1306_spi4_tx #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .clk_div_i(clk_div_i),
    .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i), .tx_dc_i(tx_dc_i),
    .tx_ready_o(tx_ready_o), .busy_o(busy_o),
    .cs_o(cs_o), .sck_o(sck_o), .sd_o(sd_o), .dc_o(dc_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];     // words expected on the wire
  int         exp_h_q[$];   // half-period H expected per byte
  int         exp_run_q[$]; // expected cs-low run lengths

  // ---------------- receiver model (samples on falling clk) ----------------
  logic [8:0] rx_q[$];
  int         rx_span_q[$]; // cycles from 1st to 8th sck rise of each byte (=14H)
  int         run_q[$];
  int         mon_bits = 0;
  int         mon_span = 0;
  int         mon_falls = 0;
  int         cs_len = 0;
  int         viol = 0;
  int         dc_chg_cnt = 0;
  int         dc_chg_falls = 0;
  logic [7:0] mon_sh = '0;
  logic       cs_p = 1'b1, sck_p = 1'b0, sd_p = 1'b0, dc_p = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      mon_bits = 0; mon_span = 0; mon_falls = 0; cs_len = 0;
      cs_p = 1'b1; sck_p = 1'b0; sd_p = 1'b0; dc_p = 1'b0;
    end else begin
      mon_span++;
      if (!cs_o) begin
        cs_len++;
      end else if (!cs_p) begin
        run_q.push_back(cs_len);
        cs_len = 0; mon_bits = 0; mon_falls = 0;
      end
      if (!cs_o && !cs_p) begin
        if (sck_p && !sck_o) mon_falls++;
        if (sck_o && (sd_o !== sd_p || dc_o !== dc_p)) viol++;
        if (dc_o !== dc_p) begin
          dc_chg_cnt++;
          dc_chg_falls = (sck_p && !sck_o) ? mon_falls : -1;
        end
      end
      if (!cs_o && sck_o && !sck_p) begin
        mon_sh = {mon_sh[6:0], sd_o};
        if (mon_bits == 0) mon_span = 0;
        mon_bits++;
        if (mon_bits == 8) begin
          rx_q.push_back({dc_o, mon_sh});
          rx_span_q.push_back(mon_span);
          mon_bits = 0;
        end
      end
      cs_p = cs_o; sck_p = sck_o; sd_p = sd_o; dc_p = dc_o;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_sb();
    exp_q.delete(); exp_h_q.delete(); exp_run_q.delete();
    rx_q.delete(); rx_span_q.delete(); run_q.delete();
    viol = 0; dc_chg_cnt = 0; dc_chg_falls = 0;
  endtask

  // All waits below start and end at posedge+1.
  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(busy_o == 1'b0 && cs_o == 1'b1) && n < LIMIT) begin
      @(posedge clk); #1; n++;
    end
    if (n == LIMIT) begin
      total++; bad++;
      $error("FAIL %s_idle_timeout observed=busy expected=idle", tag);
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic push_try(input logic [8:0] w, output logic acc);
    tx_valid_i = 1'b1; tx_dc_i = w[8]; tx_data_i = w[7:0];
    acc = tx_ready_o;
    @(posedge clk); #1;
    tx_valid_i = 1'b0;
    if (acc) exp_q.push_back(w);
  endtask

  task automatic push_wait(input logic [8:0] w);
    int n = 0;
    logic acc;
    while (!tx_ready_o && n < LIMIT) begin @(posedge clk); #1; n++; end
    if (n == LIMIT) begin
      total++; bad++;
      $error("FAIL push_timeout observed=ready0 expected=ready1");
    end
    push_try(w, acc);
  endtask

  // Burst model: cs low for 16*H per byte plus H of the final byte.
  function automatic int burst_len(input int hs[$]);
    int s = 0;
    foreach (hs[i]) s += 16 * hs[i];
    return s + hs[hs.size()-1];
  endfunction

  task automatic check_phase(input string tag);
    wait_idle(tag);
    check({tag, "_nwords"}, rx_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < rx_q.size()) check({tag, "_word"}, rx_q[i], exp_q[i]);
    check({tag, "_nspan"}, rx_span_q.size(), exp_h_q.size());
    foreach (exp_h_q[i]) if (i < rx_span_q.size()) check({tag, "_span"}, rx_span_q[i], 14 * exp_h_q[i]);
    check({tag, "_nruns"}, run_q.size(), exp_run_q.size());
    foreach (exp_run_q[i]) if (i < run_q.size()) check({tag, "_cs_low"}, run_q[i], exp_run_q[i]);
    check({tag, "_stable_hi"}, viol, 0);
    clear_sb();
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_cs"},   cs_o, 1);
    check({tag, "_sck"},  sck_o, 0);
    check({tag, "_sd"},   sd_o, 0);
    check({tag, "_dc"},   dc_o, 0);
    check({tag, "_rdy"},  tx_ready_o, 1);
    check({tag, "_busy"}, busy_o, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic acc;
    int   hs[$];
    int   n, h, k;
    logic [8:0] w;

    repeat (3) @(posedge clk);
    #1;
    check_reset_pins("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    clear_sb();

    // Single byte 0xA5 dc=1, H=2 -> 34-cycle cs low.
    clk_div_i = 8'd1;
    push_wait({1'b1, 8'hA5});
    exp_h_q.push_back(2); exp_run_q.push_back(34);
    check_phase("single");

    // Four back-to-back commands at maximum rate -> 65 cycles.
    clk_div_i = 8'd0;
    push_wait({1'b0, 8'hAE}); push_wait({1'b0, 8'hD5});
    push_wait({1'b0, 8'h80}); push_wait({1'b0, 8'h8D});
    hs = '{1, 1, 1, 1};
    foreach (hs[i]) exp_h_q.push_back(hs[i]);
    exp_run_q.push_back(burst_len(hs));
    check_phase("burst4");

    // Fill: FIFO_DEPTH+2 attempts; first is popped at once, FIFO_DEPTH more queue.
    clk_div_i = 8'd20;
    for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
      push_try({1'b1, 8'(8'h10 + i)}, acc);
      check("fill_ready", acc, (i < FIFO_DEPTH + 1) ? 1 : 0);
    end
    check("fill_busy", busy_o, 1);
    hs.delete();
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin hs.push_back(21); exp_h_q.push_back(21); end
    exp_run_q.push_back(burst_len(hs));
    check_phase("fill");

    // dc toggle: dc may only change at the fall after byte 1's 8th bit.
    clk_div_i = 8'd0;
    push_wait({1'b0, 8'h21}); push_wait({1'b1, 8'hFF});
    wait_idle("dctog_pre");
    check("dctog_changes", dc_chg_cnt, 1);
    check("dctog_at_fall8", dc_chg_falls, 8);
    exp_h_q = '{1, 1}; exp_run_q.push_back(33);
    check_phase("dctog");

    // Reset during the 4th bit of 0x3C.
    clk_div_i = 8'd1;
    push_wait({1'b1, 8'h3C});
    n = 0;
    while (!(mon_bits == 3 && sck_o == 1'b0) && n < LIMIT) begin @(posedge clk); #1; n++; end
    check("rst_reached_bit4", mon_bits, 3);
    rst = 1'b1;
    #1;
    check("rst_async_cs", cs_o, 1);
    check("rst_async_sck", sck_o, 0);
    check("rst_async_busy", busy_o, 0);
    repeat (2) @(negedge clk);
    check_reset_pins("rst_mid");
    clear_sb();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push_wait({1'b1, 8'h55});
    exp_h_q.push_back(2); exp_run_q.push_back(34);
    check_phase("after_rst");

    // clk_div changed during byte 1: byte 1 keeps H=2, byte 2 gets H=4.
    clk_div_i = 8'd1;
    push_wait({1'b1, 8'h5A}); push_wait({1'b1, 8'hC3});
    n = 0;
    while (mon_bits < 1 && n < LIMIT) begin @(posedge clk); #1; n++; end
    clk_div_i = 8'd3;
    hs = '{2, 4};
    exp_h_q = '{2, 4}; exp_run_q.push_back(burst_len(hs));
    check_phase("divchg");

    // Random bursts.
    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(0, 3);
      clk_div_i = DIV_W'(k);
      h = k + 1;
      n = $urandom_range(1, 8);
      hs.delete();
      for (int i = 0; i < n; i++) begin
        w = 9'($urandom);
        push_wait(w);
        hs.push_back(h); exp_h_q.push_back(h);
      end
      exp_run_q.push_back(burst_len(hs));
      check_phase("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
